alu_rr_scheduler: RTL

//  Time-shares the single combinational ALU among NREQ requesters (fetch/exec/debug ports).

---
 rtl/alu_rr_scheduler_pkg.sv | 23 ++
 rtl/alu_rr_scheduler_rr_arbiter.sv | 35 +++
 rtl/alu_rr_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_rr_scheduler_pkg.sv
// Shared constants for the ALU round-robin scheduler: opcodes, FSM encodings
// and the illegal-opcode check used when capturing the ALU result.
package alu_rr_scheduler_pkg;

  // ALU opcodes; 3'b000 and 3'b111 are reserved and treated as illegal.
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;

  // Scheduler FSM encodings.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // True for opcodes the ALU does not implement.
  function automatic logic op_illegal(input logic [2:0] op);
    return !(op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT});
  endfunction

endpackage

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting index at or
// after ptr, wrapping around, and returns it one-hot and encoded.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  logic [NREQ-1:0] below_ptr;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick;

  // Requests at or above ptr win first; if none, wrap to the full vector.
  assign below_ptr = (NREQ'(1) << ptr) - NREQ'(1);
  assign masked    = req & ~below_ptr;
  assign pick      = (|masked) ? masked : req;
  // Isolate the lowest set bit of the chosen vector.
  assign gnt       = pick & (~pick + NREQ'(1));
  assign any       = |req;

  // One-hot to binary: each index bit is the OR of grants whose index has it set.
  for (genvar bi = 0; bi < ID_W; bi++) begin : g_enc
    logic [NREQ-1:0] sel;
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
      assign sel[gi] = gnt[gi] & (((gi >> bi) & 1) == 1);
    end
    assign gnt_idx[bi] = |sel;
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Time-shares one combinational ALU among NREQ requesters. A request is
// granted round-robin, its op/operands are held on the ALU for one EXEC cycle,
// and the registered result is returned with the requester id over a
// valid/ready response channel.
module alu_rr_scheduler
  import alu_rr_scheduler_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int ID_W   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [3*NREQ-1:0]      req_opcode,
  input  logic [DATA_W*NREQ-1:0] req_op_a,
  input  logic [DATA_W*NREQ-1:0] req_op_b,
  output logic [2:0]             alu_opcode,
  output logic [DATA_W-1:0]      alu_op_a,
  output logic [DATA_W-1:0]      alu_op_b,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic                   alu_overflow,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_ovf,
  output logic                   rsp_err,
  output logic                   busy
);

  logic [1:0]        state_q,    state_d;
  logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [ID_W-1:0]   gnt_q,      gnt_d;
  logic [2:0]        op_q,       op_d;
  logic [DATA_W-1:0] a_q,        a_d;
  logic [DATA_W-1:0] b_q,        b_d;
  logic [ID_W-1:0]   rsp_id_q,   rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_ovf_q,  rsp_ovf_d;
  logic              rsp_err_q,  rsp_err_d;

  logic [2:0]        opc_arr [NREQ];
  logic [DATA_W-1:0] a_arr   [NREQ];
  logic [DATA_W-1:0] b_arr   [NREQ];

  logic [NREQ-1:0]   arb_gnt;
  logic [ID_W-1:0]   arb_idx;
  logic              arb_any;
  logic              arb_en;
  logic              grant_fire;

  // Split the flattened request buses into per-requester views.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign opc_arr[gi] = req_opcode[3*gi +: 3];
    assign a_arr[gi]   = req_op_a[DATA_W*gi +: DATA_W];
    assign b_arr[gi]   = req_op_b[DATA_W*gi +: DATA_W];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // A grant may be issued from IDLE, or from RESP in the same cycle the
  // response is taken (back-to-back). Held off while reset is asserted.
  assign arb_en     = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
  assign grant_fire = arb_en && arb_any && rst_n;
  assign req_ready  = grant_fire ? arb_gnt : '0;

  // ALU inputs are parked at zero while idle, latched values otherwise.
  assign alu_opcode = (state_q == S_IDLE) ? '0 : op_q;
  assign alu_op_a   = (state_q == S_IDLE) ? '0 : a_q;
  assign alu_op_b   = (state_q == S_IDLE) ? '0 : b_q;

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != S_IDLE);

  // Next-state logic: FSM transitions, operand latch on grant, result capture in EXEC.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_fire) state_d = S_EXEC;
      end
      S_EXEC: begin
        rsp_id_d = gnt_q;
        if (op_illegal(op_q)) begin
          rsp_data_d = '0;
          rsp_ovf_d  = 1'b0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_result;
          rsp_ovf_d  = alu_overflow;
          rsp_err_d  = 1'b0;
        end
        rr_ptr_d = (gnt_q == ID_W'(NREQ - 1)) ? '0 : gnt_q + ID_W'(1);
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = grant_fire ? S_EXEC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (grant_fire) begin
      gnt_d = arb_idx;
      op_d  = opc_arr[arb_idx];
      a_d   = a_arr[arb_idx];
      b_d   = b_arr[arb_idx];
    end
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

endmodule
